// File: rtl/axis_test_pkg.sv
// Shared definitions for the stream test master/sink pair:
// register map, STATUS bit positions and sink FSM states.
package axis_test_pkg;

    localparam logic [7:0] ADDR_CONTROL_REG    = 8'h00;
    localparam logic [7:0] ADDR_STATUS_REG     = 8'h04;
    localparam logic [7:0] ADDR_BEAT_COUNT_REG = 8'h08;
    localparam logic [7:0] ADDR_ERR_COUNT_REG  = 8'h0C;
    localparam logic [7:0] ADDR_NUM_BYTES_REG  = 8'h10;
    localparam logic [7:0] ADDR_THROTTLE_REG   = 8'h18;

    localparam int CTRL_ARM   = 0;
    localparam int CTRL_CLEAR = 1;

    localparam int ST_BUSY      = 0;
    localparam int ST_DONE      = 1;
    localparam int ST_DATA_ERR  = 2;
    localparam int ST_LAST_ERR  = 3;
    localparam int ST_CFG_ERR   = 4;
    localparam int ST_TDEST_LSB = 8;
    localparam int ST_TID_LSB   = 16;

    typedef enum logic [1:0] {
        SINK_IDLE = 2'd0,
        SINK_RECV = 2'd1,
        SINK_DONE = 2'd2
    } sink_state_t;

endpackage

// File: rtl/axi_lite_regif.sv
// AXI4-Lite slave handshake: one outstanding write, registered read data.
// Exposes a write strobe/address/data and a read address/mux input.
module axi_lite_regif #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic [AW-1:0] S_AXI_AWADDR,
    input  logic          S_AXI_AWVALID,
    output logic          S_AXI_AWREADY,
    input  logic [DW-1:0] S_AXI_WDATA,
    input  logic          S_AXI_WVALID,
    output logic          S_AXI_WREADY,
    output logic [1:0]    S_AXI_BRESP,
    output logic          S_AXI_BVALID,
    input  logic          S_AXI_BREADY,
    input  logic [AW-1:0] S_AXI_ARADDR,
    input  logic          S_AXI_ARVALID,
    output logic          S_AXI_ARREADY,
    output logic [DW-1:0] S_AXI_RDATA,
    output logic [1:0]    S_AXI_RRESP,
    output logic          S_AXI_RVALID,
    input  logic          S_AXI_RREADY,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data
);

    logic          aw_held;
    logic          w_held;
    logic [AW-1:0] aw_addr_q;
    logic [DW-1:0] w_data_q;
    logic          aw_fire;
    logic          w_fire;
    logic          ar_fire;

    assign S_AXI_AWREADY = !aw_held && !S_AXI_BVALID;
    assign S_AXI_WREADY  = !w_held && !S_AXI_BVALID;
    assign S_AXI_ARREADY = !S_AXI_RVALID;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RRESP   = 2'b00;

    assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;

    // Either half may arrive first; commit once both are present.
    assign wr_en   = (aw_held || aw_fire) && (w_held || w_fire);
    assign wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
    assign wr_data = w_held ? w_data_q : S_AXI_WDATA;
    assign rd_addr = S_AXI_ARADDR;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
        end else begin
            if (S_AXI_BVALID && S_AXI_BREADY)
                S_AXI_BVALID <= 1'b0;
            if (wr_en) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
            end else begin
                if (aw_fire) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= S_AXI_AWADDR;
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                end
            end
            if (ar_fire) begin
                S_AXI_RDATA  <= rd_data;
                S_AXI_RVALID <= 1'b1;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_stream_sink.sv
// Counting-pattern stream checker with AXI-Lite control/status.
// Optional AXIS_SINK_THROTTLE_EN paces TREADY from the THROTTLE register.
module axi_stream_sink
    import axis_test_pkg::*;
#(
    parameter int STREAM_DATA_WIDTH  = 32,
    parameter int STREAM_ID_WIDTH    = 2,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic [STREAM_DATA_WIDTH-1:0]    TDATA,
    input  logic                            TLAST,
    input  logic [STREAM_ID_WIDTH-1:0]      TID,
    input  logic [1:0]                      TDEST,
    input  logic                            TVALID,
    output logic                            TREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int BYTES = STREAM_DATA_WIDTH / 8;

    localparam logic [AW-1:0] A_CTRL = AW'(ADDR_CONTROL_REG);
    localparam logic [AW-1:0] A_STAT = AW'(ADDR_STATUS_REG);
    localparam logic [AW-1:0] A_BEAT = AW'(ADDR_BEAT_COUNT_REG);
    localparam logic [AW-1:0] A_ERR  = AW'(ADDR_ERR_COUNT_REG);
    localparam logic [AW-1:0] A_NUMB = AW'(ADDR_NUM_BYTES_REG);
    localparam logic [AW-1:0] A_THR  = AW'(ADDR_THROTTLE_REG);

    logic          wr_en;
    logic [AW-1:0] wr_addr, rd_addr, wa, ra;
    logic [DW-1:0] wr_data, rd_data;

    axi_lite_regif #(.DW(DW), .AW(AW)) u_regif (
        .clock(clock), .resetn(resetn),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    assign wa = {wr_addr[AW-1:2], 2'b00};
    assign ra = {rd_addr[AW-1:2], 2'b00};

    sink_state_t state, state_n;
    logic [31:0] num_bytes, beat_count, err_count, exp_data, pos;
    logic [31:0] last_pos, thr_rd, status, rd_mux;
    logic [23:0] expected_beats;
    logic [STREAM_ID_WIDTH-1:0]   tid_q;
    logic [1:0]                   tdest_q;
    logic [STREAM_DATA_WIDTH-1:0] exp_ext;
    logic done_f, last_err, cfg_err, tready_q, tready_n;
    logic arm, clear, eb_zero, fire, bad_data;

    assign expected_beats = num_bytes[23:0] / 24'(BYTES);
    assign eb_zero  = (expected_beats == 24'd0);
    assign last_pos = {8'd0, expected_beats} - 32'd1;

    assign arm   = wr_en && (wa == A_CTRL) && wr_data[CTRL_ARM];
    assign clear = wr_en && (wa == A_CTRL) && wr_data[CTRL_CLEAR] && !arm;

    always_comb begin
        exp_ext       = '0;
        exp_ext[31:0] = exp_data;
    end

    assign TREADY   = tready_q;
    assign fire     = TVALID && tready_q && (state == SINK_RECV);
    assign bad_data = (TDATA != exp_ext);

    always_comb begin
        state_n = state;
        if (arm) begin
            if (!eb_zero)
                state_n = SINK_RECV;
            else if (state == SINK_RECV)
                state_n = SINK_IDLE;
        end else if (fire && TLAST) begin
            state_n = SINK_DONE;
        end
    end

`ifdef AXIS_SINK_THROTTLE_EN
    logic [7:0] throttle, thr_cnt, thr_nxt;

    // One ready cycle followed by THROTTLE idle cycles.
    assign thr_nxt  = (thr_cnt >= throttle) ? 8'd0 : thr_cnt + 8'd1;
    assign tready_n = (state_n == SINK_RECV) && (arm || thr_nxt == 8'd0);
    assign thr_rd   = {24'd0, throttle};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            throttle <= 8'd0;
            thr_cnt  <= 8'd0;
        end else begin
            thr_cnt <= arm ? 8'd0 : thr_nxt;
            if (wr_en && wa == A_THR)
                throttle <= wr_data[7:0];
        end
    end
`else
    assign tready_n = (state_n == SINK_RECV);
    assign thr_rd   = 32'd0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= SINK_IDLE;
            tready_q   <= 1'b0;
            num_bytes  <= '0;
            beat_count <= '0;
            err_count  <= '0;
            exp_data   <= '0;
            pos        <= '0;
            tid_q      <= '0;
            tdest_q    <= '0;
            done_f     <= 1'b0;
            last_err   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state    <= state_n;
            tready_q <= tready_n;
            if (wr_en && wa == A_NUMB)
                num_bytes <= wr_data[31:0];
            if (arm) begin
                if (eb_zero) begin
                    cfg_err <= 1'b1;
                end else begin
                    beat_count <= '0;
                    err_count  <= '0;
                    exp_data   <= '0;
                    pos        <= '0;
                    done_f     <= 1'b0;
                    last_err   <= 1'b0;
                    cfg_err    <= 1'b0;
                end
            end else begin
                if (clear) begin
                    beat_count <= '0;
                    err_count  <= '0;
                    done_f     <= 1'b0;
                    last_err   <= 1'b0;
                    cfg_err    <= 1'b0;
                end
                if (fire) begin
                    exp_data <= exp_data + 32'd1;
                    pos      <= pos + 32'd1;
                    tid_q    <= TID;
                    tdest_q  <= TDEST;
                    if (!clear) begin
                        beat_count <= beat_count + 32'd1;
                        if (bad_data && err_count != 32'hFFFF_FFFF)
                            err_count <= err_count + 32'd1;
                    end
                    if (TLAST) begin
                        done_f <= 1'b1;
                        if (pos < last_pos)
                            last_err <= 1'b1;
                    end else if (pos == last_pos) begin
                        last_err <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        status                                   = '0;
        status[ST_BUSY]                          = (state == SINK_RECV);
        status[ST_DONE]                          = done_f;
        status[ST_DATA_ERR]                      = (err_count != 32'd0);
        status[ST_LAST_ERR]                      = last_err;
        status[ST_CFG_ERR]                       = cfg_err;
        status[ST_TDEST_LSB +: 2]                = tdest_q;
        status[ST_TID_LSB +: STREAM_ID_WIDTH]    = tid_q;
    end

    always_comb begin
        rd_mux = 32'd0;
        unique case (1'b1)
            (ra == A_STAT): rd_mux = status;
            (ra == A_BEAT): rd_mux = beat_count;
            (ra == A_ERR):  rd_mux = err_count;
            (ra == A_NUMB): rd_mux = num_bytes;
            (ra == A_THR):  rd_mux = thr_rd;
            default:        rd_mux = 32'd0;
        endcase
    end

    assign rd_data = DW'(rd_mux);

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                         wr_addr[1:0], rd_addr[1:0],
                         num_bytes[31:24], wr_data};

endmodule

// File: tb/tb_axi_stream_sink.sv
// Directed bench for axi_stream_sink: register access, packet checks,
// reset mid-packet and, with AXIS_SINK_THROTTLE_EN, TREADY pacing.
module tb_axi_stream_sink;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] TDATA = '0;
    logic        TLAST = 1'b0;
    logic [1:0]  TID = '0;
    logic [1:0]  TDEST = '0;
    logic        TVALID = 1'b0;
    logic        TREADY;
    logic [4:0]  AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [4:0]  ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    axi_stream_sink dut (
        .clock(clock), .resetn(resetn),
        .TDATA(TDATA), .TLAST(TLAST), .TID(TID), .TDEST(TDEST),
        .TVALID(TVALID), .TREADY(TREADY),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(3'b000),
        .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(4'hF),
        .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID),
        .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(3'b000),
        .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP),
        .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic axi_write(input logic [4:0] addr,
                             input logic [31:0] data,
                             input int w_delay);
        int  n;
        bit  aw_ok, w_ok, ok;
        AWADDR  = addr;
        WDATA   = data;
        AWVALID = 1'b1;
        WVALID  = (w_delay == 0);
        n = 0;
        while ((AWVALID || WVALID || n < w_delay) && n < 40) begin
            aw_ok = AWVALID && AWREADY;
            w_ok  = WVALID && WREADY;
            step();
            n++;
            if (aw_ok) AWVALID = 1'b0;
            if (w_ok) WVALID = 1'b0;
            if (n == w_delay) WVALID = 1'b1;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        BREADY  = 1'b1;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 20) begin
            ok = BVALID;
            if (ok) check("bresp", {30'd0, BRESP}, 32'd0);
            step();
            n++;
        end
        BREADY = 1'b0;
        check("b_wait", {31'd0, ok}, 32'd1);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] addr,
                            input logic [31:0] exp);
        int          n;
        bit          ar_ok, got;
        logic [31:0] data;
        data    = 32'hDEAD_BEEF;
        ARADDR  = addr;
        ARVALID = 1'b1;
        n = 0;
        while (ARVALID && n < 20) begin
            ar_ok = ARREADY;
            step();
            n++;
            if (ar_ok) ARVALID = 1'b0;
        end
        ARVALID = 1'b0;
        RREADY  = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 20) begin
            if (RVALID) begin
                got  = 1'b1;
                data = RDATA;
            end
            step();
            n++;
        end
        RREADY = 1'b0;
        check({tag, "_rwait"}, {31'd0, got}, 32'd1);
        check(tag, data, exp);
    endtask

    task automatic send(input logic [31:0] d, input logic last,
                        output int fire_cyc);
        int n;
        bit done;
        TDATA  = d;
        TLAST  = last;
        TVALID = 1'b1;
        done = 1'b0;
        fire_cyc = -1;
        n = 0;
        while (!done && n < 50) begin
            if (TREADY) begin
                done = 1'b1;
                fire_cyc = cyc;
            end
            step();
            n++;
        end
        check("t_wait", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int fc;
        int c0;
        int n;
        bit seen;

        repeat (3) @(posedge clock);
        #1;
        check("rst_tready", {31'd0, TREADY}, 32'd0);
        check("rst_bvalid", {31'd0, BVALID}, 32'd0);
        check("rst_rvalid", {31'd0, RVALID}, 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        check("rst_resp", {28'd0, BRESP, RRESP}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        step();

        // zero-beat configuration
        axi_write(5'h10, 32'd2, 0);
        axi_write(5'h00, 32'd1, 0);
        rd_check("cfg_status", 5'h04, 32'h10);
        for (int i = 0; i < 3; i++) begin
            check("cfg_tready", {31'd0, TREADY}, 32'd0);
            step();
        end

        // AW leads W by three cycles
        axi_write(5'h10, 32'd16, 3);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (BVALID) seen = 1'b1;
            step();
        end
        check("single_b", {31'd0, seen}, 32'd0);
        rd_check("numb_rd", 5'h10, 32'd16);
        rd_check("beat_idle", 5'h08, 32'd0);
        rd_check("ctrl_rd", 5'h00, 32'd0);
        rd_check("unmapped", 5'h14, 32'd0);
        axi_write(5'h18, 32'd5, 0);
`ifdef AXIS_SINK_THROTTLE_EN
        rd_check("thr_rd", 5'h18, 32'd5);
        axi_write(5'h18, 32'd0, 0);
`else
        rd_check("thr_rd", 5'h18, 32'd0);
`endif

        // clean packet
        axi_write(5'h00, 32'd1, 0);
        rd_check("busy", 5'h04, 32'h1);
        for (int i = 0; i < 4; i++) send(i, i == 3, fc);
        TVALID = 1'b0;
        step();
        check("p1_tready", {31'd0, TREADY}, 32'd0);
        rd_check("p1_beat", 5'h08, 32'd4);
        rd_check("p1_err", 5'h0C, 32'd0);
        rd_check("p1_status", 5'h04, 32'h2);

        // data error, TID/TDEST capture
        TID   = 2'd2;
        TDEST = 2'd1;
        axi_write(5'h00, 32'd1, 0);
        send(32'd0, 1'b0, fc);
        send(32'd1, 1'b0, fc);
        send(32'd7, 1'b0, fc);
        send(32'd3, 1'b1, fc);
        TVALID = 1'b0;
        TID    = 2'd0;
        TDEST  = 2'd0;
        rd_check("p2_err", 5'h0C, 32'd1);
        rd_check("p2_beat", 5'h08, 32'd4);
        rd_check("p2_status", 5'h04, 32'h0002_0106);

        // early TLAST
        axi_write(5'h00, 32'd1, 0);
        send(32'd0, 1'b0, fc);
        send(32'd1, 1'b1, fc);
        TVALID = 1'b0;
        rd_check("p3_beat", 5'h08, 32'd2);
        rd_check("p3_status", 5'h04, 32'hA);

        // late TLAST
        axi_write(5'h00, 32'd1, 0);
        for (int i = 0; i < 6; i++) send(i, i == 5, fc);
        TVALID = 1'b0;
        rd_check("p4_beat", 5'h08, 32'd6);
        rd_check("p4_err", 5'h0C, 32'd0);
        rd_check("p4_status", 5'h04, 32'hA);

        // CLEAR, then ARM+CLEAR together
        axi_write(5'h00, 32'd2, 0);
        rd_check("clr_status", 5'h04, 32'h0);
        rd_check("clr_beat", 5'h08, 32'd0);
        axi_write(5'h00, 32'd3, 0);
        rd_check("armclr_status", 5'h04, 32'h1);

        // reset mid-packet
        send(32'd0, 1'b0, fc);
        send(32'd1, 1'b0, fc);
        @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check("mid_rst_tready", {31'd0, TREADY}, 32'd0);
        check("mid_rst_rvalid", {31'd0, RVALID}, 32'd0);
        TVALID = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        step();
        rd_check("rst_status", 5'h04, 32'h0);
        rd_check("rst_beat", 5'h08, 32'd0);
        rd_check("rst_err", 5'h0C, 32'd0);
        rd_check("rst_numb", 5'h10, 32'd0);
        axi_write(5'h10, 32'd16, 0);
        axi_write(5'h00, 32'd1, 0);
        for (int i = 0; i < 4; i++) send(i, i == 3, fc);
        TVALID = 1'b0;
        rd_check("p5_beat", 5'h08, 32'd4);
        rd_check("p5_err", 5'h0C, 32'd0);
        rd_check("p5_status", 5'h04, 32'h2);

`ifdef AXIS_SINK_THROTTLE_EN
        axi_write(5'h18, 32'd2, 0);
        axi_write(5'h00, 32'd1, 0);
        seen = 1'b0;
        c0 = 0;
        n = 0;
        while (!seen && n < 20) begin
            if (TREADY) begin
                seen = 1'b1;
                c0 = cyc;
            end else begin
                step();
            end
            n++;
        end
        check("thr_first", {31'd0, seen}, 32'd1);
        send(32'd0, 1'b0, fc);
        check("thr_gap", {31'd0, TREADY}, 32'd0);
        send(32'd1, 1'b0, fc);
        send(32'd2, 1'b0, fc);
        send(32'd3, 1'b1, fc);
        TVALID = 1'b0;
        check("thr_span", fc - c0, 32'd9);
        rd_check("thr_beat", 5'h08, 32'd4);
        rd_check("thr_status", 5'h04, 32'h2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
